led_pattern_scheduler: RTL and testbench
========================================

// Module: led_pattern_scheduler
// PURPOSE
//  Sequences the 16-LED bank through one of four selectable blink patterns.
//  A programmable prescaler sets the step rate; single-stepping is also supported.
//  Sits between board switches/buttons and the led[15:0] pins.
//  Replaces the fixed end-to-end blinker with a mode-selectable scheduler.
// PARAMETERS
//  WIDTH     16        LED bank width (>=4)
//  TICK_DIV  33554432  clk cycles per auto step (2**25); must be >=2; sims use 4
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      asynchronous, active-high reset
//  mode       in   2      requested pattern: 0 ENDS, 1 SCAN, 2 COUNT, 3 FILL
//  mode_load  in   1      1-cycle pulse; mode is sampled on this edge
//  run        in   1      level; 1 = auto-advance on prescaler tick
//  step       in   1      1-cycle pulse; advances one step when run=0
//  led        out  WIDTH  registered LED drive
//  step_tick  out  1      registered 1-cycle pulse, high with each new led value
//  mode_q     out  2      currently active mode
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation):
//   led=1<<(WIDTH-1), mode_q=ENDS, prescaler=0, scan dir=up, step_tick=0.
//  Prescaler: counts 0..TICK_DIV-1 while run=1; held at 0 while run=0.
//   First step after run rises therefore takes a full TICK_DIV cycles.
//  adv on an edge = (run & prescaler==TICK_DIV-1) | (!run & step).
//   step is ignored while run=1.
//   On an adv edge: led<=next(led), prescaler<=0, step_tick<=1.
//   Otherwise step_tick<=0.
//  Latency: new led and step_tick appear together, 1 cycle after the adv edge.
//  mode_load has priority over adv in the same cycle; no step_tick is produced.
//   On load: mode_q<=mode, led<=seed(mode), prescaler<=0, dir<=up.
//   Reloading the same mode restarts it.
//  Seeds and next() per mode:
//   ENDS  seed 1<<(W-1); alternates 1<<(W-1) <-> 1.
//         Any other value forces 1<<(W-1).
//   SCAN  seed 1; one-hot bounce.
//         Up: shift left; at bit W-1 set dir=down and go to bit W-2.
//         Down: shift right; at bit 0 set dir=up and go to bit 1.
//         Period 2*(W-1) steps; the end bits are never held for two steps.
//   COUNT seed 0; led+1 modulo 2**W; all-ones wraps to 0.
//   FILL  seed 0; led<={led[W-2:0],1'b1}; all-ones -> 0.
//         Period W+1 steps.
//  No combinational path from inputs to outputs.
// STRUCTURE
//  Shared package led_pkg holds:
//   - mode_t enum (MODE_ENDS=0, MODE_SCAN=1, MODE_COUNT=2, MODE_FILL=3)
//   - function seed_f(mode_t) for per-mode seeds
//  Sub-module led_prescaler(clk,rst,en,clr -> tick) wraps the TICK_DIV counter.
//   Counter width is $clog2(TICK_DIV).
//  Top holds the mode register, scan dir bit, next-pattern mux and output regs.
// TESTING (WIDTH=16, TICK_DIV=4)
//  1 Reset, run=1 -> led=8000, then 0001, then 8000.
//    Each change is 4 cycles apart, step_tick pulses once per change.
//  2 Load SCAN, run=1, 32 ticks -> 0001,0002..8000,4000..0001,0002.
//    No repeat at the ends.
//  3 Load COUNT at FFFF-1 region via 65535 steps -> FFFF then 0000.
//    step_tick high on the wrap.
//  4 run=0, step pulses in FILL -> 0001,0003,..,FFFF,0000.
//    step while run=1 gives no extra advance.
//  5 mode_load and adv in the same cycle -> seed loaded, step_tick=0.
//    Next adv is a full 4 cycles later.
//  6 rst asserted mid-SCAN between edges -> led=8000 and mode_q=0 immediately.
//    Operation resumes as in test 1 after release.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and seed helper for the LED pattern scheduler.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ENDS  = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_FILL  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  localparam int MAX_W = 64;

  // Callers truncate the result to their own bank width.
  function automatic logic [MAX_W-1:0] seed_f(
    input mode_t m,
    input int    w = 16
  );
    logic [MAX_W-1:0] s;
    s = '0;
    case (m)
      MODE_ENDS: s = MAX_W'(1) << (w - 1);
      MODE_SCAN: s = MAX_W'(1);
      default:   s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: free-runs while enabled, parked at zero otherwise.
module led_prescaler
  import led_pkg::*;
#(
  parameter int TICK_DIV = 33554432
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en || clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Mode-selectable LED pattern sequencer with prescaled or single-step advance.
module led_pattern_scheduler
  import led_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 33554432
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             mode_load,
  input  logic             run,
  input  logic             step,
  output logic [WIDTH-1:0] led,
  output logic             step_tick,
  output logic [1:0]       mode_q
);

  localparam logic [WIDTH-1:0] TOP = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_t            mode_cur_q, mode_cur_d;
  dir_t             dir_q, dir_d;
  logic [WIDTH-1:0] led_q, led_d, nxt;
  dir_t             nxt_dir;
  logic             tick_q, tick_d;
  logic             pre_tick, adv;

  led_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (mode_load),
    .tick (pre_tick)
  );

  assign adv = run ? pre_tick : step;

  always_comb begin
    nxt     = led_q;
    nxt_dir = dir_q;
    case (mode_cur_q)
      MODE_ENDS: nxt = (led_q == TOP) ? ONE : TOP;
      MODE_SCAN: begin
        // Bounce turns around on the end bit so it is shown only once.
        if (dir_q == DIR_UP) begin
          if (led_q[WIDTH-1]) begin
            nxt     = led_q >> 1;
            nxt_dir = DIR_DN;
          end else begin
            nxt = led_q << 1;
            if (nxt[WIDTH-1]) nxt_dir = DIR_DN;
          end
        end else begin
          if (led_q[0]) begin
            nxt     = led_q << 1;
            nxt_dir = DIR_UP;
          end else begin
            nxt = led_q >> 1;
            if (nxt[0]) nxt_dir = DIR_UP;
          end
        end
      end
      MODE_COUNT: nxt = led_q + ONE;
      default:    nxt = (&led_q) ? '0 : {led_q[WIDTH-2:0], 1'b1};
    endcase
  end

  always_comb begin
    mode_cur_d = mode_cur_q;
    dir_d      = dir_q;
    led_d      = led_q;
    tick_d     = 1'b0;
    if (mode_load) begin
      mode_cur_d = mode_t'(mode);
      led_d      = WIDTH'(seed_f(mode_t'(mode), WIDTH));
      dir_d      = DIR_UP;
    end else if (adv) begin
      led_d  = nxt;
      dir_d  = nxt_dir;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_cur_q <= MODE_ENDS;
      dir_q      <= DIR_UP;
      led_q      <= TOP;
      tick_q     <= 1'b0;
    end else begin
      mode_cur_q <= mode_cur_d;
      dir_q      <= dir_d;
      led_q      <= led_d;
      tick_q     <= tick_d;
    end
  end

  assign led       = led_q;
  assign step_tick = tick_q;
  assign mode_q    = mode_cur_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic vs a step-index model.
module tb_led_pattern_scheduler;

  localparam int W  = 16;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         rst, run, step, mode_load;
  logic [1:0]   mode;
  logic [W-1:0] led;
  logic         step_tick;
  logic [1:0]   mode_q;

  int n_vec = 0;
  int n_err = 0;

  int m_mode, m_idx, m_pc;
  bit m_tick;

  always #5 clk = ~clk;

  led_pattern_scheduler #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .mode_load (mode_load),
    .run       (run),
    .step      (step),
    .led       (led),
    .step_tick (step_tick),
    .mode_q    (mode_q)
  );

  // Pattern is a pure function of mode and number of steps since seed.
  function automatic logic [W-1:0] exp_led();
    int k;
    case (m_mode)
      0: return (m_idx % 2 == 0) ? 16'h8000 : 16'h0001;
      1: begin
        k = m_idx % 30;
        return 16'(32'd1 << ((k <= 15) ? k : 30 - k));
      end
      2: return 16'(m_idx % 65536);
      default: begin
        k = m_idx % 17;
        return 16'((32'd1 << k) - 1);
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic cyc();
    bit adv;
    logic [W-1:0] e;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_idx = 0; m_pc = 0; m_tick = 0;
    end else begin
      adv = run ? (m_pc == TD - 1) : step;
      if (mode_load) begin
        m_mode = int'(mode); m_idx = 0; m_pc = 0; m_tick = 0;
      end else begin
        if (adv) m_idx++;
        m_tick = adv;
        m_pc = (run && m_pc != TD - 1) ? m_pc + 1 : 0;
      end
    end
    #1;
    e = exp_led();
    n_vec++;
    if (led !== e || step_tick !== m_tick || mode_q !== 2'(m_mode)) begin
      n_err++;
      $display("FAIL cycle t=%0t led=%h/%h tick=%b/%b mode=%0d/%0d",
               $time, led, e, step_tick, m_tick, mode_q, m_mode);
    end
  endtask

  task automatic load(input logic [1:0] m);
    mode = m; mode_load = 1'b1;
    cyc();
    mode_load = 1'b0;
  endtask

  initial begin
    logic [W-1:0] seq[$];
    int budget, reps, g, ticks;
    rst = 1'b1; run = 1'b0; step = 1'b0; mode_load = 1'b0; mode = 2'd0;
    repeat (2) cyc();
    chk("rst_led", 32'(led), 32'h8000);
    chk("rst_mode", 32'(mode_q), 0);
    chk("rst_tick", 32'(step_tick), 0);

    // ENDS auto-run
    rst = 1'b0; run = 1'b1;
    repeat (3) cyc();
    chk("t1_hold", 32'(led), 32'h8000);
    cyc();
    chk("t1_first", 32'(led), 32'h0001);
    chk("t1_tick", 32'(step_tick), 1);
    repeat (4) cyc();
    chk("t1_second", 32'(led), 32'h8000);

    // SCAN bounce
    load(2'd1);
    chk("t2_seed", 32'(led), 32'h0001);
    chk("t2_seed_tick", 32'(step_tick), 0);
    seq.push_back(led);
    budget = 0;
    while (seq.size() < 33 && budget < 200) begin
      cyc(); budget++;
      if (step_tick) seq.push_back(led);
    end
    chk("t2_ticks", 32'(seq.size()), 33);
    if (seq.size() >= 32) begin
      chk("t2_top", 32'(seq[15]), 32'h8000);
      chk("t2_turn", 32'(seq[16]), 32'h4000);
      chk("t2_bottom", 32'(seq[30]), 32'h0001);
      chk("t2_rise", 32'(seq[31]), 32'h0002);
    end
    reps = 0;
    for (int i = 1; i < seq.size(); i++) if (seq[i] == seq[i-1]) reps++;
    chk("t2_norepeat", 32'(reps), 0);

    // load collides with a prescaler adv
    budget = 0;
    while (m_pc != TD - 1 && budget < 10) begin cyc(); budget++; end
    load(2'd2);
    chk("t5_seed", 32'(led), 0);
    chk("t5_notick", 32'(step_tick), 0);
    g = 0;
    do begin cyc(); g++; end while (!step_tick && g < 10);
    chk("t5_gap", 32'(g), 4);

    // COUNT wrap via single steps
    run = 1'b0;
    load(2'd2);
    step = 1'b1;
    repeat (65535) cyc();
    chk("t3_ffff", 32'(led), 32'hFFFF);
    cyc();
    chk("t3_wrap", 32'(led), 0);
    chk("t3_wrap_tick", 32'(step_tick), 1);
    step = 1'b0;

    // FILL single steps
    load(2'd3);
    for (int i = 1; i <= 17; i++) begin
      step = 1'b1; cyc();
      step = 1'b0; cyc();
      if (i == 1)  chk("t4_s1", 32'(led), 32'h0001);
      if (i == 2)  chk("t4_s2", 32'(led), 32'h0003);
      if (i == 16) chk("t4_full", 32'(led), 32'hFFFF);
      if (i == 17) chk("t4_empty", 32'(led), 0);
    end
    run = 1'b1; step = 1'b1; ticks = 0;
    repeat (3) begin cyc(); ticks += int'(step_tick); end
    chk("t4_step_ignored", 32'(ticks), 0);
    cyc();
    chk("t4_run_adv", 32'(led), 32'h0001);
    step = 1'b0;

    // async reset mid-SCAN
    load(2'd1);
    repeat (10) cyc();
    #2 rst = 1'b1;
    #1;
    chk("t6_led", 32'(led), 32'h8000);
    chk("t6_mode", 32'(mode_q), 0);
    chk("t6_tick", 32'(step_tick), 0);
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk("t6_hold", 32'(led), 32'h8000);
    cyc();
    chk("t6_resume", 32'(led), 32'h0001);

    // random traffic
    repeat (3000) begin
      run       = ($urandom_range(0, 3) != 0);
      step      = 1'($urandom_range(0, 1));
      mode_load = ($urandom_range(0, 15) == 0);
      mode      = 2'($urandom_range(0, 3));
      rst       = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0; mode_load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
